// File: rtl/mvau_sched_pkg.sv
// mvau_sched_pkg: shared state type and fold-size helpers for the MVAU weight-memory scheduler
package mvau_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} sched_state_t;
  function automatic int sf_of(int matrixw, int simd);
    return matrixw / simd;
  endfunction
  function automatic int nf_of(int matrixh, int pe);
    return matrixh / pe;
  endfunction
  function automatic int cw(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mvau_fold_cnt.sv
// mvau_fold_cnt: 0..MAX-1 fold counter with combinational last and wrap strobes
module mvau_fold_cnt
  import mvau_sched_pkg::*;
#(
  parameter int MAX = 2
) (
  input  logic                 aclk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clear,
  output logic [cw(MAX)-1:0]   cnt,
  output logic                 last,
  output logic                 wrap
);
  localparam int W = cw(MAX);
  localparam logic [W-1:0] TOP = W'(MAX - 1);
  logic [W-1:0] cnt_q;
  assign cnt  = cnt_q;
  assign last = cnt_q == TOP;
  assign wrap = en & last;
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (clear) cnt_q <= '0;
    else if (en) cnt_q <= last ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/mvau_wmem_sched.sv
// mvau_wmem_sched: weight-memory address sequencer with side-band flags aligned to the 1-cycle memory read
module mvau_wmem_sched
  import mvau_sched_pkg::*;
#(
  parameter int SIMD         = 2,
  parameter int PE           = 2,
  parameter int MATRIXW      = 4,
  parameter int MATRIXH      = 4,
  parameter int NUM_VEC      = 2,
  parameter int WMEM_DEPTH   = MATRIXW * MATRIXH / (SIMD * PE),
  parameter int WMEM_ADDR_BW = cw(WMEM_DEPTH)
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_v,
  input  logic                    out_rdy,
  output logic                    in_rd,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic                    w_valid,
  output logic                    sf_first,
  output logic                    sf_last
);
  localparam int SF = sf_of(MATRIXW, SIMD);
  localparam int NF = nf_of(MATRIXH, PE);
  if (MATRIXW % SIMD != 0 || MATRIXH % PE != 0 || SF * NF != WMEM_DEPTH) begin : g_bad_cfg
    $error("mvau_wmem_sched: illegal fold configuration");
  end
  sched_state_t            state_q;
  logic                    done_q, w_valid_q, sf_first_q, sf_last_q;
  logic [WMEM_ADDR_BW-1:0] wmem_addr_q;
  logic [cw(SF)-1:0]       sf_cnt;
  logic [cw(NF)-1:0]       nf_cnt;
  logic [cw(NUM_VEC)-1:0]  vec_cnt;
  logic                    adv, idle, sf_end, nf_end, vec_end, sf_wrap, nf_wrap, vec_wrap;
  assign idle      = state_q == IDLE;
  assign adv       = (state_q == RUN) & in_v & out_rdy;
  assign in_rd     = adv;
  assign busy      = !idle;
  assign done      = done_q;
  assign wmem_addr = wmem_addr_q;
  assign w_valid   = w_valid_q;
  assign sf_first  = sf_first_q;
  assign sf_last   = sf_last_q;
  mvau_fold_cnt #(.MAX(SF)) u_sf (
    .aclk(aclk), .rst(rst), .en(adv), .clear(idle), .cnt(sf_cnt), .last(sf_end), .wrap(sf_wrap)
  );
  mvau_fold_cnt #(.MAX(NF)) u_nf (
    .aclk(aclk), .rst(rst), .en(sf_wrap), .clear(idle), .cnt(nf_cnt), .last(nf_end), .wrap(nf_wrap)
  );
  mvau_fold_cnt #(.MAX(NUM_VEC)) u_vec (
    .aclk(aclk), .rst(rst), .en(nf_wrap), .clear(idle), .cnt(vec_cnt), .last(vec_end), .wrap(vec_wrap)
  );
  // Flags are registered at the advance so they line up with the memory's registered read data.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      w_valid_q   <= 1'b0;
      sf_first_q  <= 1'b0;
      sf_last_q   <= 1'b0;
      wmem_addr_q <= '0;
    end else begin
      w_valid_q  <= adv;
      sf_first_q <= adv & (sf_cnt == '0);
      sf_last_q  <= adv & sf_end;
      done_q     <= state_q == FLUSH;
      if (adv) wmem_addr_q <= wmem_addr_q == WMEM_ADDR_BW'(WMEM_DEPTH - 1) ? '0 : wmem_addr_q + 1'b1;
      state_q <= idle ? (start ? RUN : IDLE) : state_q == RUN ? (vec_wrap ? FLUSH : RUN) : IDLE;
    end
  end
  // The linear address must always equal the fold position; counters rest at zero while idle.
  always_ff @(posedge aclk) begin
    if (!rst)
      assert (wmem_addr_q == WMEM_ADDR_BW'(nf_cnt * SF + sf_cnt) && (!idle || vec_cnt == '0)
              && (!vec_wrap || (nf_end && vec_end)));
  end
endmodule

// File: tb/tb_mvau_wmem_sched.sv
// tb_mvau_wmem_sched: random and directed checks of the scheduler against a product-index model
module tb_mvau_wmem_sched;
  localparam int SF = 2, DEPTH = 4, TOTAL = 8;
  logic       aclk = 1'b0, rst = 1'b1, start = 1'b0, in_v = 1'b0, out_rdy = 1'b0;
  logic       busy, done, in_rd, w_valid, sf_first, sf_last;
  logic [1:0] wmem_addr;
  logic       start1 = 1'b0, in_v1 = 1'b1, out_rdy1 = 1'b1;
  logic       busy1, done1, in_rd1, w_valid1, sf_first1, sf_last1;
  logic [1:0] wmem_addr1;
  mvau_wmem_sched dut (
    .aclk(aclk), .rst(rst), .start(start), .busy(busy), .done(done), .in_v(in_v),
    .out_rdy(out_rdy), .in_rd(in_rd), .wmem_addr(wmem_addr), .w_valid(w_valid),
    .sf_first(sf_first), .sf_last(sf_last)
  );
  mvau_wmem_sched #(.SIMD(2), .PE(1), .MATRIXW(2), .MATRIXH(4), .NUM_VEC(1)) dut1 (
    .aclk(aclk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .in_v(in_v1),
    .out_rdy(out_rdy1), .in_rd(in_rd1), .wmem_addr(wmem_addr1), .w_valid(w_valid1),
    .sf_first(sf_first1), .sf_last(sf_last1)
  );
  always #5 aclk = ~aclk;

  int cmp = 0, err = 0, cyc = 0, rd_cnt = 0;
  int addr_log[$], wv_cyc[$], done_cyc[$];
  bit first_log[$], last_log[$];
  int addr1_log[$], wv1_cyc[$], done1_cyc[$];
  bit first1_log[$], last1_log[$];
  bit m_busy = 0, m_run = 0, e_wv = 0, e_first = 0, e_last = 0, e_done = 0;
  int k = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a run is TOTAL products; product k reads address k mod DEPTH, first/last by k mod SF.
  always @(negedge aclk) begin
    bit adv, flush, was_idle;
    cyc++;
    if (rst) begin
      chk("reset_outputs", {busy, done, w_valid, sf_first, sf_last, wmem_addr}, 0);
      m_busy = 0; m_run = 0; k = 0; e_wv = 0; e_first = 0; e_last = 0; e_done = 0;
    end else begin
      adv = m_run && in_v && out_rdy;
      flush = m_busy && !m_run;
      was_idle = !m_busy;
      chk("busy", busy, m_busy);
      chk("in_rd", in_rd, adv);
      chk("wmem_addr", wmem_addr, k % DEPTH);
      chk("w_valid", w_valid, e_wv);
      chk("done", done, e_done);
      if (e_wv) begin
        chk("sf_first", sf_first, e_first);
        chk("sf_last", sf_last, e_last);
      end
      if (in_rd) begin addr_log.push_back(int'(wmem_addr)); rd_cnt++; end
      if (w_valid) begin first_log.push_back(sf_first); last_log.push_back(sf_last); wv_cyc.push_back(cyc); end
      if (done) done_cyc.push_back(cyc);
      e_wv = adv;
      e_first = adv && (k % SF == 0);
      e_last = adv && (k % SF == SF - 1);
      e_done = flush;
      if (flush) m_busy = 0;
      if (adv) begin
        k++;
        if (k == TOTAL) begin k = 0; m_run = 0; end
      end
      if (was_idle && start) begin m_run = 1; m_busy = 1; end
    end
  end

  always @(negedge aclk) begin
    if (!rst) begin
      if (in_rd1) addr1_log.push_back(int'(wmem_addr1));
      if (w_valid1) begin first1_log.push_back(sf_first1); last1_log.push_back(sf_last1); wv1_cyc.push_back(cyc); end
      if (done1) done1_cyc.push_back(cyc);
    end
  end

  task automatic check_run(string tag, int a0, int f0, int d0);
    chk({tag, "_nadv"}, addr_log.size() - a0, TOTAL);
    chk({tag, "_nvalid"}, first_log.size() - f0, TOTAL);
    chk({tag, "_ndone"}, done_cyc.size() - d0, 1);
    if (addr_log.size() - a0 == TOTAL)
      for (int i = 0; i < TOTAL; i++) chk({tag, "_addr_seq"}, addr_log[a0 + i], i % 4);
    if (first_log.size() - f0 == TOTAL) begin
      for (int i = 0; i < TOTAL; i++) begin
        chk({tag, "_first_seq"}, first_log[f0 + i], (i % 2 == 0) ? 1 : 0);
        chk({tag, "_last_seq"}, last_log[f0 + i], (i % 2 == 1) ? 1 : 0);
      end
      if (done_cyc.size() > d0) chk({tag, "_done_lag"}, done_cyc[d0] - wv_cyc[f0 + TOTAL - 1], 1);
    end
  endtask

  // mode 0 plain, 1 three-cycle out_rdy stall at addr 2, 2 in_v toggling, 3 start spam in RUN/FLUSH
  task automatic run(string tag, int mode);
    int a0, f0, d0, r0, n, stall_left;
    bit stalled;
    a0 = addr_log.size(); f0 = first_log.size(); d0 = done_cyc.size(); r0 = rd_cnt;
    n = 0; stall_left = 0; stalled = 0;
    @(posedge aclk); #1;
    start = 1; in_v = 1; out_rdy = 1;
    do begin
      @(posedge aclk); #1;
      start = 0; n++;
      if (mode == 1) begin
        if (stall_left > 0) begin
          chk({tag, "_addr_hold"}, wmem_addr, 2);
          stall_left--; out_rdy = 0;
        end else if (!stalled && wmem_addr == 2) begin
          out_rdy = 0; stall_left = 2; stalled = 1;
        end else out_rdy = 1;
      end
      if (mode == 2) in_v = ~in_v;
      if (mode == 3) start = (n == 3) || (m_busy && !m_run);
    end while (done_cyc.size() == d0 && n < 100);
    start = 0; in_v = 1; out_rdy = 1;
    if (n >= 100) chk({tag, "_timeout"}, 0, 1);
    repeat (3) @(posedge aclk);
    #1;
    check_run(tag, a0, f0, d0);
    if (mode == 1) chk({tag, "_stalled"}, stalled, 1);
    if (mode == 2) chk({tag, "_in_rd_count"}, rd_cnt - r0, TOTAL);
    if (mode == 3) chk({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int d0, n;
    repeat (2) @(posedge aclk);
    #1 rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_addr", wmem_addr, 0);
    chk("rst_done", done, 0);
    run("plain", 0);
    run("stall", 1);
    run("toggle", 2);
    run("start_spam", 3);
    // reset mid-run at address 3 of the first vector
    d0 = done_cyc.size(); n = 0;
    @(posedge aclk); #1;
    start = 1; in_v = 1; out_rdy = 1;
    @(posedge aclk); #1;
    start = 0;
    while (wmem_addr != 2'd3 && n < 20) begin @(posedge aclk); #1; n++; end
    chk("rst_reach_addr3", wmem_addr, 3);
    #1 rst = 1;
    #1;
    chk("async_rst_outs", {busy, done, w_valid, sf_first, sf_last, wmem_addr}, 0);
    @(posedge aclk); #1 rst = 0;
    repeat (6) @(posedge aclk);
    #1;
    chk("rst_no_done", done_cyc.size() - d0, 0);
    run("after_rst", 0);
    // randomized traffic, then drain
    for (int i = 0; i < 400; i++) begin
      @(posedge aclk); #1;
      in_v = $urandom_range(0, 3) != 0;
      out_rdy = $urandom_range(0, 3) != 0;
      start = $urandom_range(0, 7) == 0;
    end
    start = 0; in_v = 1; out_rdy = 1;
    repeat (30) @(posedge aclk);
    #1;
    chk("rand_drained", busy, 0);
    // SF=1, NF=4, one vector
    @(posedge aclk); #1 start1 = 1;
    @(posedge aclk); #1 start1 = 0;
    n = 0;
    while (done1_cyc.size() == 0 && n < 50) begin @(posedge aclk); n++; end
    repeat (2) @(posedge aclk);
    #1;
    chk("sf1_nadv", addr1_log.size(), 4);
    chk("sf1_nvalid", first1_log.size(), 4);
    chk("sf1_ndone", done1_cyc.size(), 1);
    if (addr1_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("sf1_addr_seq", addr1_log[i], i);
    if (first1_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("sf1_first", first1_log[i], 1);
        chk("sf1_last", last1_log[i], 1);
      end
      if (done1_cyc.size() == 1) chk("sf1_done_lag", done1_cyc[0] - wv1_cyc[3], 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
